risc_selfcheck_unit: RTL and testbench

//  Synthesizable end-of-program checker for the pipelined RV64 core; replaces bench-side register peeks.

---
 rtl/risc_selfcheck_unit.sv | 225 ++++++++++++++++++++++
 tb/tb_risc_selfcheck_unit.sv | 430 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/risc_selfcheck_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : risc_selfcheck_unit                                          |
// | Description : End-of-program checker for the pipelined RV64 core. Traces   |
// |               data-memory stores into a FIFO, counts RUN cycles, then      |
// |               walks a table of expected register values through a regfile  |
// |               read port and reports pass/fail on done.                     |
// | Config      : SELFCHECK_CONT_EN - check every entry and count all          |
// |               mismatches (default: stop at the first mismatch).            |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module risc_selfcheck_unit #(
  parameter int XLEN        = 64,
  parameter int NUM_CHECKS  = 8,
  parameter int TRACE_DEPTH = 16,
  parameter int CYCLE_LIMIT = 200,
  parameter int CNT_W       = 16,
  localparam int IDX_W      = $clog2(NUM_CHECKS),
  localparam int AW         = $clog2(TRACE_DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              mem_we,
  input  logic [XLEN-1:0]   mem_addr,
  input  logic [XLEN-1:0]   mem_wdata,
  input  logic              exp_we,
  input  logic [IDX_W-1:0]  exp_idx,
  input  logic [4:0]        exp_reg,
  input  logic [XLEN-1:0]   exp_val,
  output logic [4:0]        rf_raddr,
  input  logic [XLEN-1:0]   rf_rdata,
  output logic              tr_valid,
  input  logic              tr_ready,
  output logic [XLEN-4:0]   tr_addr,
  output logic [XLEN-1:0]   tr_data,
  output logic              trace_ovf,
  output logic [CNT_W-1:0]  cycle_cnt,
  output logic              done,
  output logic              pass,
  output logic [IDX_W-1:0]  fail_idx,
  output logic [XLEN-1:0]   fail_val,
  output logic [IDX_W:0]    fail_cnt
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_CHECK = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

`ifdef SELFCHECK_CONT_EN
  localparam bit STOP_ON_FAIL = 1'b0;
`else
  localparam bit STOP_ON_FAIL = 1'b1;
`endif

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cycle_cnt_q, cycle_cnt_d;
  logic [IDX_W-1:0] chk_idx_q, chk_idx_d;
  logic [IDX_W-1:0] fail_idx_q, fail_idx_d;
  logic [XLEN-1:0]  fail_val_q, fail_val_d;
  logic [IDX_W:0]   fail_cnt_q, fail_cnt_d;
  logic             trace_ovf_q, trace_ovf_d;
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic [4:0]       exp_reg_q [NUM_CHECKS];
  logic [4:0]       exp_reg_d [NUM_CHECKS];
  logic [XLEN-1:0]  exp_val_q [NUM_CHECKS];
  logic [XLEN-1:0]  exp_val_d [NUM_CHECKS];

  // Store-trace payload; only the head entry is ever observed, gated by tr_valid.
  logic [XLEN-4:0]  fifo_addr_mem [TRACE_DEPTH];
  logic [XLEN-1:0]  fifo_data_mem [TRACE_DEPTH];

  logic        w_restart;
  logic        w_entry_valid;
  logic        w_mismatch;
  logic        w_last;
  logic [AW:0] w_count;
  logic        w_empty;
  logic        w_full;
  logic        w_push_req;
  logic        w_pop;
  logic        w_push_ok;
  logic        w_unused_addr_lsbs;

  // Byte offset within a doubleword is not traced.
  assign w_unused_addr_lsbs = ^mem_addr[2:0];

  // Shared decode: restart is only honoured from IDLE or DONE; FIFO status and compare result.
  always_comb begin
    w_restart     = start && ((state_q == S_IDLE) || (state_q == S_DONE));
    w_entry_valid = (exp_reg_q[chk_idx_q] != 5'd0);
    w_mismatch    = (state_q == S_CHECK) && w_entry_valid && (rf_rdata != exp_val_q[chk_idx_q]);
    w_last        = (chk_idx_q == IDX_W'(NUM_CHECKS - 1));
    w_count       = wr_ptr_q - rd_ptr_q;
    w_empty       = (wr_ptr_q == rd_ptr_q);
    w_full        = (w_count == (AW+1)'(TRACE_DEPTH));
    w_push_req    = (state_q == S_RUN) && mem_we;
    w_pop         = !w_empty && tr_ready;
    // A full FIFO can still take a store when the head leaves in the same cycle.
    w_push_ok     = w_push_req && (!w_full || w_pop);
  end

  // State and datapath registers, all cleared by the asynchronous reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      cycle_cnt_q <= '0;
      chk_idx_q   <= '0;
      fail_idx_q  <= '0;
      fail_val_q  <= '0;
      fail_cnt_q  <= '0;
      trace_ovf_q <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      for (int i = 0; i < NUM_CHECKS; i++) begin
        exp_reg_q[i] <= '0;
        exp_val_q[i] <= '0;
      end
    end else begin
      state_q     <= state_d;
      cycle_cnt_q <= cycle_cnt_d;
      chk_idx_q   <= chk_idx_d;
      fail_idx_q  <= fail_idx_d;
      fail_val_q  <= fail_val_d;
      fail_cnt_q  <= fail_cnt_d;
      trace_ovf_q <= trace_ovf_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      for (int i = 0; i < NUM_CHECKS; i++) begin
        exp_reg_q[i] <= exp_reg_d[i];
        exp_val_q[i] <= exp_val_d[i];
      end
    end
  end

  // Trace storage write port; no reset needed since reads are masked while empty.
  always_ff @(posedge clk) begin
    if (w_push_ok) begin
      fifo_addr_mem[wr_ptr_q[AW-1:0]] <= mem_addr[XLEN-1:3];
      fifo_data_mem[wr_ptr_q[AW-1:0]] <= mem_wdata;
    end
  end

  // Next-state logic for the check sequencer.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_RUN;
      S_RUN:   if (cycle_cnt_q == CNT_W'(CYCLE_LIMIT - 1)) state_d = S_CHECK;
      S_CHECK: if (w_last || (STOP_ON_FAIL && w_mismatch)) state_d = S_DONE;
      S_DONE:  if (start) state_d = S_RUN;
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath next values: cycle counter, check walker, failure capture, table and FIFO pointers.
  always_comb begin
    cycle_cnt_d = cycle_cnt_q;
    chk_idx_d   = chk_idx_q;
    fail_idx_d  = fail_idx_q;
    fail_val_d  = fail_val_q;
    fail_cnt_d  = fail_cnt_q;
    trace_ovf_d = trace_ovf_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    for (int i = 0; i < NUM_CHECKS; i++) begin
      exp_reg_d[i] = exp_reg_q[i];
      exp_val_d[i] = exp_val_q[i];
    end

    // The expected table survives restarts; it is frozen only while being walked.
    if (exp_we && (state_q != S_CHECK)) begin
      exp_reg_d[exp_idx] = exp_reg;
      exp_val_d[exp_idx] = exp_val;
    end

    if (w_restart) begin
      cycle_cnt_d = '0;
      chk_idx_d   = '0;
      fail_idx_d  = '0;
      fail_val_d  = '0;
      fail_cnt_d  = '0;
      trace_ovf_d = 1'b0;
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
    end else begin
      if ((state_q == S_RUN) && (cycle_cnt_q != {CNT_W{1'b1}})) begin
        cycle_cnt_d = cycle_cnt_q + CNT_W'(1);
      end
      if (state_q == S_CHECK) begin
        chk_idx_d = chk_idx_q + IDX_W'(1);
        if (w_mismatch) begin
          fail_cnt_d = fail_cnt_q + (IDX_W+1)'(1);
          // Only the first mismatch is reported in detail.
          if (fail_cnt_q == '0) begin
            fail_idx_d = chk_idx_q;
            fail_val_d = rf_rdata;
          end
        end
      end
      if (w_push_ok) wr_ptr_d = wr_ptr_q + (AW+1)'(1);
      if (w_pop)     rd_ptr_d = rd_ptr_q + (AW+1)'(1);
      if (w_push_req && !w_push_ok) trace_ovf_d = 1'b1;
    end
  end

  // Output decode from state and registered status.
  always_comb begin
    done      = (state_q == S_DONE);
    pass      = (state_q == S_DONE) && (fail_cnt_q == '0);
    rf_raddr  = (state_q == S_CHECK) ? exp_reg_q[chk_idx_q] : 5'd0;
    tr_valid  = !w_empty;
    tr_addr   = w_empty ? '0 : fifo_addr_mem[rd_ptr_q[AW-1:0]];
    tr_data   = w_empty ? '0 : fifo_data_mem[rd_ptr_q[AW-1:0]];
    trace_ovf = trace_ovf_q;
    cycle_cnt = cycle_cnt_q;
    fail_idx  = fail_idx_q;
    fail_val  = fail_val_q;
    fail_cnt  = fail_cnt_q;
  end

endmodule
`default_nettype wire

// File: tb/tb_risc_selfcheck_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_risc_selfcheck_unit                                       |
// | Description : Scoreboard bench for risc_selfcheck_unit with a regfile      |
// |               model; honours SELFCHECK_CONT_EN when defined.               |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_risc_selfcheck_unit;

  localparam int XLEN  = 64;
  localparam int NC    = 8;
  localparam int TD    = 16;
  localparam int CL    = 200;
  localparam int CNT_W = 16;
  localparam int IDX_W = 3;
  localparam int BUDGET = 2000;

`ifdef SELFCHECK_CONT_EN
  localparam bit CONT = 1'b1;
`else
  localparam bit CONT = 1'b0;
`endif

  typedef struct {
    logic             pass;
    logic [IDX_W-1:0] idx;
    logic [XLEN-1:0]  val;
    logic [IDX_W:0]   cnt;
    int               cycles;
  } chk_t;

  typedef struct {
    logic [XLEN-4:0] a;
    logic [XLEN-1:0] d;
  } tr_t;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic             mem_we;
  logic [XLEN-1:0]  mem_addr;
  logic [XLEN-1:0]  mem_wdata;
  logic             exp_we;
  logic [IDX_W-1:0] exp_idx;
  logic [4:0]       exp_reg;
  logic [XLEN-1:0]  exp_val;
  logic [4:0]       rf_raddr;
  logic [XLEN-1:0]  rf_rdata;
  logic             tr_valid;
  logic             tr_ready;
  logic [XLEN-4:0]  tr_addr;
  logic [XLEN-1:0]  tr_data;
  logic             trace_ovf;
  logic [CNT_W-1:0] cycle_cnt;
  logic             done;
  logic             pass;
  logic [IDX_W-1:0] fail_idx;
  logic [XLEN-1:0]  fail_val;
  logic [IDX_W:0]   fail_cnt;

  logic [XLEN-1:0] rf [32];
  chk_t chk_q[$];
  tr_t  tr_q[$];
  int   n_vec = 0;
  int   n_err = 0;

  assign rf_rdata = rf[rf_raddr];

  always #5 clk = ~clk;

  risc_selfcheck_unit #(
    .XLEN(XLEN), .NUM_CHECKS(NC), .TRACE_DEPTH(TD), .CYCLE_LIMIT(CL), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst(rst), .start(start),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .exp_we(exp_we), .exp_idx(exp_idx), .exp_reg(exp_reg), .exp_val(exp_val),
    .rf_raddr(rf_raddr), .rf_rdata(rf_rdata),
    .tr_valid(tr_valid), .tr_ready(tr_ready), .tr_addr(tr_addr), .tr_data(tr_data),
    .trace_ovf(trace_ovf), .cycle_cnt(cycle_cnt),
    .done(done), .pass(pass), .fail_idx(fail_idx), .fail_val(fail_val), .fail_cnt(fail_cnt)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input int idx, input int r, input logic [XLEN-1:0] v);
    exp_we  = 1'b1;
    exp_idx = IDX_W'(idx);
    exp_reg = 5'(r);
    exp_val = v;
    tick();
    exp_we  = 1'b0;
  endtask

  task automatic load_matching_table();
    load(0, 1, 64'd5);  load(1, 2, 64'd3);  load(2, 3, 64'd11); load(3, 4, 64'd17);
    load(4, 5, 64'd29); load(5, 6, 64'd8);  load(6, 7, 64'd29);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic store(input logic [XLEN-1:0] a, input logic [XLEN-1:0] d);
    mem_we    = 1'b1;
    mem_addr  = a;
    mem_wdata = d;
    tick();
    mem_we    = 1'b0;
  endtask

  // Count edges after the start edge until done rises (bounded).
  task automatic wait_done(output int n);
    n = 0;
    while (!done && n < BUDGET) begin
      tick();
      n++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    tick();
    tick();
    n_vec++;
    if ({rf_raddr, tr_valid, tr_addr, tr_data, trace_ovf, cycle_cnt, done, pass,
         fail_idx, fail_val, fail_cnt} !== '0) begin
      n_err++;
      $display("FAIL reset_outputs: got done=%0b pass=%0b tr_valid=%0b cycle_cnt=%0d fail_cnt=%0d, required all zero",
               done, pass, tr_valid, cycle_cnt, fail_cnt);
    end
    #3 rst = 1'b1;
    tick();
  endtask

  task automatic test_pass();
    chk_t e;
    int   n;
    load_matching_table();
    e.pass = 1'b1; e.idx = '0; e.val = '0; e.cnt = '0; e.cycles = CL + NC;
    chk_q.push_back(e);
    pulse_start();
    n_vec++;
    if (done !== 1'b0 || cycle_cnt !== 16'd0) begin
      n_err++;
      $display("FAIL pass_run_entry: got done=%0b cycle_cnt=%0d, required done=0 cycle_cnt=0", done, cycle_cnt);
    end
    wait_done(n);
    e = chk_q.pop_front();
    n_vec++;
    if (n !== e.cycles) begin
      n_err++;
      $display("FAIL pass_latency: done at cycle %0d after start, required %0d", n + 1, e.cycles + 1);
    end
    n_vec++;
    if ({pass, fail_idx, fail_val, fail_cnt} !== {e.pass, e.idx, e.val, e.cnt}) begin
      n_err++;
      $display("FAIL pass_result: got pass=%0b idx=%0d val=%0h cnt=%0d, required pass=%0b idx=%0d val=%0h cnt=%0d",
               pass, fail_idx, fail_val, fail_cnt, e.pass, e.idx, e.val, e.cnt);
    end
    n_vec++;
    if (cycle_cnt !== 16'(CL)) begin
      n_err++;
      $display("FAIL pass_cycle_cnt_hold: got %0d, required %0d", cycle_cnt, CL);
    end
  endtask

  task automatic test_mismatch();
    chk_t e;
    int   n;
    for (int k = 0; k < 2; k++) begin
      if (k == 0) load(2, 3, 64'd12);
      else        load(4, 5, 64'd30);
      e.pass = 1'b0; e.idx = 3'd2; e.val = 64'd11;
      e.cnt    = (CONT && k == 1) ? 4'd2 : 4'd1;
      e.cycles = CONT ? (CL + NC) : (CL + 3);
      chk_q.push_back(e);
      pulse_start();
      wait_done(n);
      e = chk_q.pop_front();
      n_vec++;
      if (n !== e.cycles) begin
        n_err++;
        $display("FAIL mismatch%0d_latency: done at cycle %0d after start, required %0d", k, n + 1, e.cycles + 1);
      end
      n_vec++;
      if ({pass, fail_idx, fail_val, fail_cnt} !== {e.pass, e.idx, e.val, e.cnt}) begin
        n_err++;
        $display("FAIL mismatch%0d_result: got pass=%0b idx=%0d val=%0h cnt=%0d, required pass=%0b idx=%0d val=%0h cnt=%0d",
                 k, pass, fail_idx, fail_val, fail_cnt, e.pass, e.idx, e.val, e.cnt);
      end
    end
    load(2, 3, 64'd11);
    load(4, 5, 64'd29);
  endtask

  task automatic test_trace_overflow();
    tr_t e;
    int  got;
    int  n;
    tr_ready = 1'b0;
    pulse_start();
    for (int i = 0; i < 17; i++) begin
      e.a = (XLEN-3)'((64'h40 + 64'(8 * i)) >> 3);
      e.d = 64'(7 + i);
      if (i < TD) tr_q.push_back(e);
      store(64'h40 + 64'(8 * i), 64'(7 + i));
      if (i == 0) begin
        n_vec++;
        if (tr_valid !== 1'b1 || tr_addr !== 61'd8 || tr_data !== 64'd7) begin
          n_err++;
          $display("FAIL trace_first_head: got valid=%0b addr=%0h data=%0h, required valid=1 addr=8 data=7",
                   tr_valid, tr_addr, tr_data);
        end
      end
    end
    n_vec++;
    if (trace_ovf !== 1'b1) begin
      n_err++;
      $display("FAIL trace_ovf_set: got %0b, required 1", trace_ovf);
    end
    got = 0;
    tr_ready = 1'b1;
    for (int c = 0; c < 40 && tr_valid; c++) begin
      if (tr_q.size() != 0) begin
        e = tr_q.pop_front();
        n_vec++;
        if (tr_addr !== e.a || tr_data !== e.d) begin
          n_err++;
          $display("FAIL trace_drain_%0d: got addr=%0h data=%0h, required addr=%0h data=%0h",
                   got, tr_addr, tr_data, e.a, e.d);
        end
      end
      got++;
      tick();
    end
    tr_ready = 1'b0;
    n_vec++;
    if (got !== TD) begin
      n_err++;
      $display("FAIL trace_drain_count: got %0d entries, required %0d", got, TD);
    end
    tr_q.delete();
    wait_done(n);
    n_vec++;
    if (n >= BUDGET || pass !== 1'b1) begin
      n_err++;
      $display("FAIL trace_run_done: got done=%0b pass=%0b, required done=1 pass=1", done, pass);
    end
  endtask

  task automatic test_fifo_corner();
    tr_t e;
    int  got;
    int  n;
    pulse_start();
    tr_ready = 1'b1;
    tick();
    tr_ready = 1'b0;
    n_vec++;
    if (tr_valid !== 1'b0) begin
      n_err++;
      $display("FAIL empty_pop_ignored: got tr_valid=%0b, required 0", tr_valid);
    end
    tr_ready = 1'b1;
    store(64'h1238, 64'hABCD);
    tr_ready = 1'b0;
    n_vec++;
    if (tr_valid !== 1'b1 || tr_addr !== 61'h247 || tr_data !== 64'hABCD) begin
      n_err++;
      $display("FAIL empty_push_pop: got valid=%0b addr=%0h data=%0h, required valid=1 addr=247 data=abcd",
               tr_valid, tr_addr, tr_data);
    end
    tr_ready = 1'b1;
    tick();
    tr_ready = 1'b0;
    for (int i = 0; i < TD; i++) begin
      e.a = (XLEN-3)'(64'h100 + 64'(i));
      e.d = 64'(100 + i);
      tr_q.push_back(e);
      store((64'h100 + 64'(i)) << 3, 64'(100 + i));
    end
    e.a = 61'h999;
    e.d = 64'h5555;
    void'(tr_q.pop_front());
    tr_q.push_back(e);
    tr_ready = 1'b1;
    store(64'h999 << 3, 64'h5555);
    tr_ready = 1'b0;
    n_vec++;
    if (trace_ovf !== 1'b0) begin
      n_err++;
      $display("FAIL full_push_pop_ovf: got trace_ovf=%0b, required 0", trace_ovf);
    end
    got = 0;
    tr_ready = 1'b1;
    for (int c = 0; c < 40 && tr_valid; c++) begin
      if (tr_q.size() != 0) begin
        e = tr_q.pop_front();
        n_vec++;
        if (tr_addr !== e.a || tr_data !== e.d) begin
          n_err++;
          $display("FAIL full_drain_%0d: got addr=%0h data=%0h, required addr=%0h data=%0h",
                   got, tr_addr, tr_data, e.a, e.d);
        end
      end
      got++;
      tick();
    end
    tr_ready = 1'b0;
    n_vec++;
    if (got !== TD) begin
      n_err++;
      $display("FAIL full_drain_count: got %0d entries, required %0d", got, TD);
    end
    tr_q.delete();
    wait_done(n);
  endtask

  task automatic test_restart();
    chk_t e;
    int   n;
    for (int k = 0; k < 2; k++) begin
      e.pass = 1'b1; e.idx = '0; e.val = '0; e.cnt = '0; e.cycles = CL + NC;
      chk_q.push_back(e);
      pulse_start();
      n = 0;
      if (k == 0) begin
        store(64'h8, 64'd1);
        store(64'h10, 64'd2);
        store(64'h18, 64'd3);
        pulse_start();
        n = 4;
      end else begin
        n_vec++;
        if (cycle_cnt !== 16'd0 || tr_valid !== 1'b0 || done !== 1'b0 || trace_ovf !== 1'b0) begin
          n_err++;
          $display("FAIL restart_clear: got cycle_cnt=%0d tr_valid=%0b done=%0b ovf=%0b, required all 0",
                   cycle_cnt, tr_valid, done, trace_ovf);
        end
      end
      begin
        int m;
        wait_done(m);
        n += m;
      end
      e = chk_q.pop_front();
      n_vec++;
      if (n !== e.cycles) begin
        n_err++;
        $display("FAIL restart%0d_latency: done at cycle %0d after start, required %0d", k, n + 1, e.cycles + 1);
      end
      n_vec++;
      if ({pass, fail_cnt} !== {e.pass, e.cnt}) begin
        n_err++;
        $display("FAIL restart%0d_result: got pass=%0b cnt=%0d, required pass=1 cnt=0", k, pass, fail_cnt);
      end
      if (k == 0) begin
        n_vec++;
        if (tr_valid !== 1'b1) begin
          n_err++;
          $display("FAIL restart_trace_held: got tr_valid=%0b, required 1", tr_valid);
        end
      end
    end
  endtask

  task automatic test_async_reset();
    chk_t e;
    int   n;
    pulse_start();
    store(64'h20, 64'd9);
    tick();
    #3 rst = 1'b0;
    #1;
    n_vec++;
    if (done !== 1'b0 || tr_valid !== 1'b0 || cycle_cnt !== 16'd0) begin
      n_err++;
      $display("FAIL async_reset_immediate: got done=%0b tr_valid=%0b cycle_cnt=%0d, required 0 0 0",
               done, tr_valid, cycle_cnt);
    end
    @(posedge clk);
    #1;
    n_vec++;
    if ({rf_raddr, tr_valid, tr_addr, tr_data, trace_ovf, cycle_cnt, done, pass,
         fail_idx, fail_val, fail_cnt} !== '0) begin
      n_err++;
      $display("FAIL async_reset_outputs: got done=%0b pass=%0b tr_valid=%0b cycle_cnt=%0d, required all zero",
               done, pass, tr_valid, cycle_cnt);
    end
    #3 rst = 1'b1;
    tick();
    // With the table cleared by reset, a corrupted register must not be noticed.
    rf[3] = 64'd99;
    e.pass = 1'b1; e.idx = '0; e.val = '0; e.cnt = '0; e.cycles = CL + NC;
    chk_q.push_back(e);
    pulse_start();
    wait_done(n);
    e = chk_q.pop_front();
    n_vec++;
    if (n !== e.cycles || {pass, fail_cnt} !== {e.pass, e.cnt}) begin
      n_err++;
      $display("FAIL table_cleared_by_reset: got cycle %0d pass=%0b cnt=%0d, required cycle %0d pass=1 cnt=0",
               n + 1, pass, fail_cnt, e.cycles + 1);
    end
  endtask

  initial begin
    start = 1'b0; mem_we = 1'b0; mem_addr = '0; mem_wdata = '0;
    exp_we = 1'b0; exp_idx = '0; exp_reg = '0; exp_val = '0; tr_ready = 1'b0;
    for (int i = 0; i < 32; i++) rf[i] = '0;
    rf[1] = 64'd5;  rf[2] = 64'd3; rf[3] = 64'd11; rf[4] = 64'd17;
    rf[5] = 64'd29; rf[6] = 64'd8; rf[7] = 64'd29;
    test_reset();
    test_pass();
    test_mismatch();
    test_trace_overflow();
    test_fifo_corner();
    test_restart();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
